// File: rtl/iob_regfile_arb_pkg.sv
// Shared definitions for the single-port register-file arbiter:
// controller state encoding and requester index constants.
package iob_regfile_arb_pkg;

    // Controller states: CLEAR zeroes the regfile, RUN serves requesters.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Requester indices, also the encoding of the round-robin pointer.
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-request round-robin arbiter. The pointer remembers the last winner;
// on a tie the other requester is granted. Grant is combinational and is
// forced to zero while en is low.
module iob_rr_arb2
    import iob_regfile_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic r_ptr;

    // Combinational one-hot grant with round-robin tie break.
    always_comb begin
        gnt = '0;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_ptr == REQ_M1) ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // Pointer follows the winner; resets to M1 so M0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= REQ_M1;
        end else if (gnt != 2'b00) begin
            r_ptr <= gnt[1];
        end
    end

endmodule

// File: rtl/iob_regfile_arb.sv
// Single-port register-file controller shared by two requesters (M0, M1).
// After reset, and on a clr pulse while running, every entry is zeroed by
// a clear sequence; otherwise requests are served round-robin, one access
// per cycle, with read data returned one cycle after the grant.
module iob_regfile_arb
    import iob_regfile_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,

    input  logic              m0_valid,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_valid,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic [DATA_W-1:0] rf_r_data
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_arb_en;
    logic              w_rd0;
    logic              w_rd1;
    logic              r_m0_rvalid;
    logic              r_m1_rvalid;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

    // Arbiter is enabled only in RUN and never in a cycle where clr wins,
    // so its pointer does not move on those cycles.
    assign w_req    = {m1_valid, m0_valid};
    assign w_arb_en = (r_state == ST_RUN) && !clr;

    iob_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (w_req),
        .en    (w_arb_en),
        .gnt   (w_gnt)
    );

    assign w_rd0 = w_gnt[REQ_M0] && !m0_we;
    assign w_rd1 = w_gnt[REQ_M1] && !m1_we;

    // Next state, clear counter and regfile/handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        busy        = 1'b0;
        rf_we       = 1'b0;
        rf_addr     = '0;
        rf_w_data   = '0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                busy    = 1'b1;
                rf_we   = 1'b1;
                rf_addr = r_cnt;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
                m0_ready = w_gnt[REQ_M0];
                m1_ready = w_gnt[REQ_M1];
                if (w_gnt[REQ_M0]) begin
                    rf_we     = m0_we;
                    rf_addr   = m0_addr;
                    rf_w_data = m0_wdata;
                end else if (w_gnt[REQ_M1]) begin
                    rf_we     = m1_we;
                    rf_addr   = m1_addr;
                    rf_w_data = m1_wdata;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and clear-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read return: rvalid pulses one cycle after a read grant; rdata holds
    // until that requester's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_rd0;
            r_m1_rvalid <= w_rd1;
            if (w_rd0) begin
                r_m0_rdata <= rf_r_data;
            end
            if (w_rd1) begin
                r_m1_rdata <= rf_r_data;
            end
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_iob_regfile_arb.sv
// Bench for iob_regfile_arb: hosts a single-port regfile model, predicts
// grants and regfile traffic each cycle, and checks returned read data
// against a per-requester scoreboard queue.
module tb_iob_regfile_arb;

    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr   = 1'b0;
    logic          busy;
    logic          m0_valid = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ready, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_valid = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ready, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_w_data;
    logic [DW-1:0] rf_r_data;

    always #5 clk = ~clk;

    iob_regfile_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_w_data(rf_w_data), .rf_r_data(rf_r_data)
    );

    // Single-port regfile: combinational read, synchronous write.
    logic [DW-1:0] rf_mem [DEPTH];
    assign rf_r_data = rf_mem[rf_addr];
    always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_w_data;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference state
    bit            mdl_clear;
    int unsigned   mdl_cnt;
    int            mdl_ptr;
    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            exp_rv0, exp_rv1;
    logic [DW-1:0] last0, last1;
    int            last_gnt;

    task automatic idle();
        m0_valid = 1'b0; m1_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic set_m0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m0_valid = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set_m1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m1_valid = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // model on the edge, then check the read-return outputs.
    task automatic step();
        int            g;
        logic          e_we;
        logic [31:0]   e_addr, e_wd;
        @(negedge clk); #1;
        g = -1; e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (mdl_clear) begin
            e_we = 1'b1; e_addr = mdl_cnt;
        end else if (!clr) begin
            if (m0_valid && m1_valid) g = (mdl_ptr == 1) ? 0 : 1;
            else if (m0_valid)        g = 0;
            else if (m1_valid)        g = 1;
            if (g == 0) begin e_we = m0_we; e_addr = 32'(m0_addr); e_wd = m0_wdata; end
            if (g == 1) begin e_we = m1_we; e_addr = 32'(m1_addr); e_wd = m1_wdata; end
        end
        chk("busy",      busy,      mdl_clear);
        chk("m0_ready",  m0_ready,  g == 0);
        chk("m1_ready",  m1_ready,  g == 1);
        chk("rf_we",     rf_we,     e_we);
        chk("rf_addr",   rf_addr,   e_addr);
        chk("rf_w_data", rf_w_data, e_wd);
        exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        if (mdl_clear) begin
            mdl_mem[mdl_cnt] = '0;
        end else if (g == 0) begin
            if (m0_we) mdl_mem[m0_addr] = m0_wdata;
            else begin q0.push_back(mdl_mem[m0_addr]); exp_rv0 = 1'b1; end
        end else if (g == 1) begin
            if (m1_we) mdl_mem[m1_addr] = m1_wdata;
            else begin q1.push_back(mdl_mem[m1_addr]); exp_rv1 = 1'b1; end
        end
        last_gnt = g;
        @(posedge clk);
        if (mdl_clear) begin
            if (mdl_cnt == DEPTH - 1) begin mdl_clear = 1'b0; mdl_cnt = 0; end
            else mdl_cnt++;
        end else if (clr) begin
            mdl_clear = 1'b1;
        end
        if (g >= 0) mdl_ptr = g;
        #1;
        chk("m0_rvalid", m0_rvalid, exp_rv0);
        if (m0_rvalid) begin
            if (q0.size() == 0) chk("m0_sb_underflow", 32'd1, 32'd0);
            else last0 = q0.pop_front();
        end
        chk("m0_rdata", m0_rdata, last0);
        chk("m1_rvalid", m1_rvalid, exp_rv1);
        if (m1_rvalid) begin
            if (q1.size() == 0) chk("m1_sb_underflow", 32'd1, 32'd0);
            else last1 = q1.pop_front();
        end
        chk("m1_rdata", m1_rdata, last1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must return at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy",      busy,      1);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_rdata",  m0_rdata,  0);
        chk("rst_m1_rdata",  m1_rdata,  0);
        mdl_clear = 1'b1; mdl_cnt = 0; mdl_ptr = 1;
        q0.delete(); q1.delete();
        last0 = '0; last1 = '0; exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        do_reset();

        // Post-reset clear of four entries, then read addr 2.
        repeat (DEPTH) step();
        set_m0(1'b0, 2'd2, '0);
        step();
        chk("post_clear_rd2", m0_rdata, 0);
        idle();
        step();

        // Single write by M0, read back by M1 the next cycle.
        set_m0(1'b1, 2'd1, 32'hDEADBEEF);
        step();
        idle();
        set_m1(1'b0, 2'd1, '0);
        step();
        chk("m1_rd_deadbeef", m1_rdata, 32'hDEADBEEF);
        idle();
        step();

        // Contention: both hold reads for four cycles, grants alternate.
        set_m0(1'b0, 2'd1, '0);
        set_m1(1'b0, 2'd2, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contend_order", last_gnt, i % 2);
        end
        idle();
        step();

        // Clear during traffic.
        for (int a = 0; a < 4; a++) begin
            set_m0(1'b1, AW'(a), 32'h11);
            step();
        end
        set_m0(1'b0, 2'd3, '0);
        clr = 1'b1;
        step();
        chk("clr_beats_req", last_gnt, -1);
        clr = 1'b0;
        repeat (DEPTH) step();
        step();
        chk("clr_rd3_gnt", last_gnt, 0);
        chk("clr_rd3_zero", m0_rdata, 0);
        idle();
        step();

        // clr during CLEAR is ignored.
        clr = 1'b1; step();
        clr = 1'b0; step();
        clr = 1'b1; step();
        clr = 1'b0; step(); step();
        step();
        chk("ignored_clr_done", busy, 0);

        // In-flight read return dropped by reset.
        set_m1(1'b0, 2'd0, '0);
        step();
        idle();
        do_reset();
        repeat (DEPTH) step();
        step();

        // Reset at clear counter 2: sequence restarts from address 0.
        clr = 1'b1; step();
        clr = 1'b0; step(); step();
        do_reset();
        repeat (DEPTH) step();
        step();

        // Random traffic; a requester not granted holds its request.
        for (int i = 0; i < 80; i++) begin
            if (!(m0_valid && last_gnt != 0))
                begin m0_valid = 1'($urandom_range(0, 1)); m0_we = 1'($urandom_range(0, 1));
                      m0_addr = AW'($urandom_range(0, DEPTH - 1)); m0_wdata = $urandom; end
            if (!(m1_valid && last_gnt != 1))
                begin m1_valid = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
                      m1_addr = AW'($urandom_range(0, DEPTH - 1)); m1_wdata = $urandom; end
            clr = ($urandom_range(0, 24) == 0);
            step();
        end
        idle();
        repeat (DEPTH + 1) step();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
